// File: rtl/fp_cmp_pkg.sv
// Shared result codes, FSM state type and chunk-count helper for fp_compare_serial.
package fp_cmp_pkg;

    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_GT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        CLASS,
        SCAN,
        DONE
    } state_e;

    // Number of DIGIT-wide chunks needed to cover the W-1 magnitude bits.
    function automatic int unsigned nchunk(input int unsigned w, input int unsigned digit);
        return (w - 32'd1 + digit - 32'd1) / digit;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Per-operand classification of a magnitude field {exp, man}.
// FP_CMP_NAN_EN enables NaN detection; otherwise is_nan_c is constant 0.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [EXP_W+MAN_W-1:0] mag_i,
    output logic                   is_zero_c,
    output logic                   is_nan_c
);

    assign is_zero_c = (mag_i == '0);

`ifdef FP_CMP_NAN_EN
    // NaN: exponent all ones with a non-zero fraction
    assign is_nan_c = (&mag_i[EXP_W+MAN_W-1:MAN_W]) && (|mag_i[MAN_W-1:0]);
`else
    assign is_nan_c = 1'b0;
`endif

endmodule

// File: rtl/fp_compare_serial.sv
// Serial MSB-first floating-point order comparator with early exit.
// Optional build macro FP_CMP_NAN_EN: NaN operands give an unordered result.
module fp_compare_serial
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           compResult,
    output logic                 unordered
);

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned MW     = W - 1;
    localparam int unsigned NCHUNK = nchunk(W, DIGIT);
    localparam int unsigned PW     = NCHUNK * DIGIT;
    localparam int unsigned PAD    = PW - MW;
    localparam int unsigned KW     = $clog2(NCHUNK) + 1;

    state_e          state_q;
    logic [W-1:0]    x_q, y_q;
    logic [KW-1:0]   k_q;
    logic            busy_q, done_q;
    logic [2:0]      res_q;

    logic [MW-1:0]   mx, my;
    logic [PW-1:0]   mx_pad, my_pad;
    logic [31:0]     sh;
    logic [DIGIT-1:0] chunk_x, chunk_y;
    logic            zero_x, zero_y, nan_x, nan_y;
    logic            accept, last_chunk, chunk_ne;
    logic [2:0]      order;

    assign mx = x_q[MW-1:0];
    assign my = y_q[MW-1:0];

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
        .mag_i     (mx),
        .is_zero_c (zero_x),
        .is_nan_c  (nan_x)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
        .mag_i     (my),
        .is_zero_c (zero_y),
        .is_nan_c  (nan_y)
    );

    // Chunk mux: magnitudes left-aligned with zero padding, chunk k taken from the top
    assign mx_pad     = PW'(mx) << PAD;
    assign my_pad     = PW'(my) << PAD;
    assign sh         = (32'(NCHUNK) - 32'd1 - 32'(k_q)) * 32'(DIGIT);
    assign chunk_x    = DIGIT'(mx_pad >> sh);
    assign chunk_y    = DIGIT'(my_pad >> sh);
    assign chunk_ne   = (chunk_x != chunk_y);
    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    // Same-sign operands: larger magnitude is smaller value when negative
    assign order      = ((chunk_x > chunk_y) ^ x_q[W-1]) ? CMP_GT : CMP_LT;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= CMP_NONE;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (accept) begin
                        x_q     <= x;
                        y_q     <= y;
                        k_q     <= '0;
                        res_q   <= CMP_NONE;
                        busy_q  <= 1'b1;
                        state_q <= CLASS;
                    end
                end
                CLASS: begin
                    k_q <= '0;
                    if (nan_x || nan_y) begin
                        res_q   <= CMP_NONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (zero_x && zero_y) begin
                        res_q   <= CMP_EQ;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (x_q[W-1] != y_q[W-1]) begin
                        res_q   <= x_q[W-1] ? CMP_LT : CMP_GT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (chunk_ne) begin
                        res_q   <= order;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (last_chunk) begin
                        res_q   <= CMP_EQ;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign compResult = res_q;

`ifdef FP_CMP_NAN_EN
    logic unord_q;

    // Unordered flag: cleared on accept, set when CLASS sees a NaN
    always_ff @(posedge clk) begin
        if (reset) begin
            unord_q <= 1'b0;
        end else if (accept) begin
            unord_q <= 1'b0;
        end else if ((state_q == CLASS) && (nan_x || nan_y)) begin
            unord_q <= 1'b1;
        end
    end

    assign unordered = unord_q;
`else
    assign unordered = 1'b0;
`endif

endmodule
